// File: rtl/ahs_pkg.sv
// ahs_pkg: shared widths, defaults and FSM state type for the ammunition manager.
package ahs_pkg;
  localparam int AMMO_W = 5;
  localparam int DEF_MAX_AMMO = 29;
  localparam int AUTO_FIRE_HOLD = 4;
  typedef enum logic [1:0] {IDLE, ARM, LAUNCH, COOLDOWN} state_t;
endpackage

// File: rtl/ammo_counter.sv
// ammo_counter: saturating magazine register; reload adds a step clamped to MAX_AMMO, fire removes one round.
module ammo_counter
  import ahs_pkg::*;
#(
  parameter int MAX_AMMO = DEF_MAX_AMMO,
  parameter int INIT_AMMO = 20,
  parameter int RELOAD_STEP = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              dec,
  input  logic              inc_step,
  output logic [AMMO_W-1:0] count,
  output logic              is_empty
);
  localparam int SW = AMMO_W + 1;
  logic [SW-1:0] sum;
  assign sum = {1'b0, count} + SW'(RELOAD_STEP);
  assign is_empty = count == '0;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) count <= AMMO_W'(INIT_AMMO);
    else count <= inc_step ? (sum > SW'(MAX_AMMO) ? AMMO_W'(MAX_AMMO) : sum[AMMO_W-1:0])
                : (dec && !is_empty) ? count - AMMO_W'(1) : count;
endmodule

// File: rtl/ammo_manager.sv
// ammo_manager: three-launcher magazine owner with arm/launch/cooldown fire sequencing.
// Optional AHS_AUTO_FIRE_EN: self-fire after a valid radar sector is held stable in IDLE.
module ammo_manager
  import ahs_pkg::*;
#(
  parameter int MAX_AMMO = DEF_MAX_AMMO,
  parameter int INIT_AMMO = 20,
  parameter int RELOAD_STEP = 5,
  parameter int COOLDOWN_CYCLES = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              radar_1,
  input  logic              radar_2,
  input  logic              radar_3,
  input  logic              fire_req,
  input  logic              reload_req,
  output logic [AMMO_W-1:0] ammunition_1,
  output logic [AMMO_W-1:0] ammunition_2,
  output logic [AMMO_W-1:0] ammunition_3,
  output logic              launch_1,
  output logic              launch_2,
  output logic              launch_3,
  output logic              busy,
  output logic              empty_fault
);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
  state_t state, state_d;
  logic [2:0] radar, sel, sel_q, empty, dec, launch;
  logic [AMMO_W-1:0] ammo [3];
  logic [CW-1:0] cd;
  logic sel_ok, sel_full, auto_fire, fire, go, reload, fault_d;
  assign radar = {radar_3, radar_2, radar_1};
  assign sel_ok = $onehot(radar);
  assign sel = sel_ok ? radar : 3'b000;
  assign sel_full = |(sel & ~empty);
  assign fire = state == IDLE && sel_ok && (fire_req || auto_fire);
  assign go = fire && sel_full;
  assign fault_d = state == IDLE && fire_req && sel_ok && !sel_full;
  assign reload = state == IDLE && reload_req && !fire;
  assign dec = state == LAUNCH ? sel_q : 3'b000;
  assign {launch_3, launch_2, launch_1} = launch;
  assign ammunition_1 = ammo[0];
  assign ammunition_2 = ammo[1];
  assign ammunition_3 = ammo[2];
  for (genvar i = 0; i < 3; i++) begin : g_mag
    ammo_counter #(.MAX_AMMO(MAX_AMMO), .INIT_AMMO(INIT_AMMO), .RELOAD_STEP(RELOAD_STEP)) u_ctr (
      .clock(clock), .reset_n(reset_n), .dec(dec[i]), .inc_step(reload),
      .count(ammo[i]), .is_empty(empty[i])
    );
  end
`ifdef AHS_AUTO_FIRE_EN
  localparam int HW = $clog2(AUTO_FIRE_HOLD);
  logic [2:0] prev_sel;
  logic [HW-1:0] hold;
  logic same;
  assign same = sel_ok && sel == prev_sel;
  // hold counts consecutive IDLE cycles the current sector has been seen
  assign auto_fire = state == IDLE && same && hold == HW'(AUTO_FIRE_HOLD - 1) && sel_full;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      prev_sel <= 3'b000;
      hold <= '0;
    end else if (state_d != IDLE) begin
      prev_sel <= 3'b000;
      hold <= '0;
    end else begin
      prev_sel <= sel;
      hold <= !sel_ok ? '0 : !same ? HW'(1) : hold == HW'(AUTO_FIRE_HOLD - 1) ? hold : hold + HW'(1);
    end
`else
  assign auto_fire = 1'b0;
`endif
  // ARM aborts when the radar no longer shows exactly the latched sector
  always_comb
    state_d = state == IDLE ? (go ? ARM : IDLE)
            : state == ARM ? (sel == sel_q ? LAUNCH : IDLE)
            : state == LAUNCH ? COOLDOWN
            : (cd == '0 ? IDLE : COOLDOWN);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      sel_q <= 3'b000;
      cd <= '0;
      launch <= 3'b000;
      busy <= 1'b0;
      empty_fault <= 1'b0;
    end else begin
      state <= state_d;
      sel_q <= go ? sel : sel_q;
      cd <= state == LAUNCH ? CW'(COOLDOWN_CYCLES - 1) : (state == COOLDOWN && cd != '0) ? cd - CW'(1) : cd;
      launch <= (state == ARM && state_d == LAUNCH) ? sel_q : 3'b000;
      busy <= state_d != IDLE;
      empty_fault <= fault_d;
    end
endmodule

// File: tb/tb_ammo_manager.sv
// tb_ammo_manager: scoreboard bench; stimulus queues expected snapshots, a negedge monitor pops and compares.
module tb_ammo_manager;
  typedef struct packed {
    logic [4:0] a1, a2, a3;
    logic [2:0] l;
    logic b, f;
  } snap_t;
  typedef struct {
    string tag;
    snap_t v;
  } exp_t;
  logic clock = 1'b0;
  logic reset_n, radar_1, radar_2, radar_3, fire_req, reload_req;
  logic [4:0] ammunition_1, ammunition_2, ammunition_3;
  logic launch_1, launch_2, launch_3, busy, empty_fault;
  exp_t sbq[$];
  exp_t cur;
  snap_t obs;
  int checks = 0;
  int errors = 0;
  ammo_manager dut (
    .clock(clock), .reset_n(reset_n),
    .radar_1(radar_1), .radar_2(radar_2), .radar_3(radar_3),
    .fire_req(fire_req), .reload_req(reload_req),
    .ammunition_1(ammunition_1), .ammunition_2(ammunition_2), .ammunition_3(ammunition_3),
    .launch_1(launch_1), .launch_2(launch_2), .launch_3(launch_3),
    .busy(busy), .empty_fault(empty_fault)
  );
  always #5 clock = ~clock;
  assign obs = '{a1: ammunition_1, a2: ammunition_2, a3: ammunition_3,
                 l: {launch_3, launch_2, launch_1}, b: busy, f: empty_fault};
  always @(negedge clock)
    if (sbq.size() > 0) begin
      cur = sbq.pop_front();
      checks++;
      if (obs !== cur.v) begin
        errors++;
        $display("FAIL %s: got ammo=%0d/%0d/%0d launch=%b busy=%b fault=%b, expected ammo=%0d/%0d/%0d launch=%b busy=%b fault=%b",
                 cur.tag, obs.a1, obs.a2, obs.a3, obs.l, obs.b, obs.f,
                 cur.v.a1, cur.v.a2, cur.v.a3, cur.v.l, cur.v.b, cur.v.f);
      end
    end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic push(input string t, input int a1, input int a2, input int a3,
                      input logic [2:0] l, input logic b, input logic f);
    exp_t e;
    e.tag = t;
    e.v = '{a1: 5'(a1), a2: 5'(a2), a3: 5'(a3), l: l, b: b, f: f};
    sbq.push_back(e);
  endtask
  task automatic set_radar(input logic [2:0] r);
    {radar_3, radar_2, radar_1} = r;
  endtask
  task automatic fire_once(input logic [2:0] r);
    set_radar(r);
    fire_req = 1'b1;
    step();
    fire_req = 1'b0;
    repeat (10) step();
    set_radar(3'b000);
  endtask
  task automatic reload_once();
    reload_req = 1'b1;
    step();
    reload_req = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end
  initial begin
    reset_n = 1'b0;
    fire_req = 1'b0;
    reload_req = 1'b0;
    set_radar(3'b000);
    step();
    push("reset", 20, 20, 20, 3'b000, 0, 0);
    reset_n = 1'b1;
    repeat (5) step();
    push("idle5", 20, 20, 20, 3'b000, 0, 0);
    // single fire on sector 1 with full cycle-by-cycle timeline
    set_radar(3'b001);
    fire_req = 1'b1;
    step();
    fire_req = 1'b0;
    push("fire1_arm", 20, 20, 20, 3'b000, 1, 0);
    step();
    push("fire1_launch", 20, 20, 20, 3'b001, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      push("fire1_cool", 19, 20, 20, 3'b000, 1, 0);
    end
    step();
    push("fire1_done", 19, 20, 20, 3'b000, 0, 0);
    set_radar(3'b000);
    step();
    set_radar(3'b011);
    fire_req = 1'b1;
    step();
    fire_req = 1'b0;
    set_radar(3'b000);
    push("invalid_sel", 19, 20, 20, 3'b000, 0, 0);
    for (int i = 0; i < 20; i++) fire_once(3'b010);
    step();
    push("mag2_drained", 19, 0, 20, 3'b000, 0, 0);
    set_radar(3'b010);
    fire_req = 1'b1;
    step();
    fire_req = 1'b0;
    push("empty_fault", 19, 0, 20, 3'b000, 0, 1);
    step();
    push("empty_fault_clr", 19, 0, 20, 3'b000, 0, 0);
    set_radar(3'b000);
    repeat (4) reload_once();
    push("setup_reload", 29, 20, 29, 3'b000, 0, 0);
    repeat (2) fire_once(3'b001);
    for (int i = 0; i < 29; i++) fire_once(3'b100);
    step();
    push("setup_fire", 27, 20, 0, 3'b000, 0, 0);
    // fire wins over reload even when the fire only raises empty_fault
    set_radar(3'b100);
    fire_req = 1'b1;
    reload_req = 1'b1;
    step();
    fire_req = 1'b0;
    reload_req = 1'b0;
    set_radar(3'b000);
    push("fault_drops_reload", 27, 20, 0, 3'b000, 0, 1);
    reload_once();
    push("reload1", 29, 25, 5, 3'b000, 0, 0);
    reload_once();
    push("reload2", 29, 29, 10, 3'b000, 0, 0);
    set_radar(3'b001);
    fire_req = 1'b1;
    step();
    fire_req = 1'b0;
    set_radar(3'b010);
    push("abort_arm", 29, 29, 10, 3'b000, 1, 0);
    step();
    push("abort_idle", 29, 29, 10, 3'b000, 0, 0);
    step();
    push("abort_nodec", 29, 29, 10, 3'b000, 0, 0);
    set_radar(3'b100);
    fire_req = 1'b1;
    reload_req = 1'b1;
    step();
    fire_req = 1'b0;
    reload_req = 1'b0;
    push("fire_over_reload", 29, 29, 10, 3'b000, 1, 0);
    step();
    push("fire_over_reload_launch", 29, 29, 10, 3'b100, 1, 0);
    step();
    push("fire_over_reload_dec", 29, 29, 9, 3'b000, 1, 0);
    step();
    reset_n = 1'b0;
    push("reset_in_cooldown", 20, 20, 20, 3'b000, 0, 0);
    step();
    reset_n = 1'b1;
    set_radar(3'b000);
    step();
    push("post_reset_idle", 20, 20, 20, 3'b000, 0, 0);
`ifdef AHS_AUTO_FIRE_EN
    set_radar(3'b001);
    repeat (4) step();
    push("auto_arm", 20, 20, 20, 3'b000, 1, 0);
    step();
    push("auto_launch", 20, 20, 20, 3'b001, 1, 0);
    step();
    push("auto_dec", 19, 20, 20, 3'b000, 1, 0);
    set_radar(3'b000);
    repeat (10) step();
`endif
    repeat (2) step();
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
